// File: rtl/mult_pkg.sv
// Shared definitions for the radix-2 Booth multiplier.
// Optional feature macro: MULT_UNSIGNED_EN (adds the Uns port, widens the
// operand path by one bit and runs one extra iteration).
package mult_pkg;

    localparam int WIDTH         = 32;
    localparam int ITER_SIGNED   = 32;
    localparam int ITER_UNSIGNED = 33;
    localparam int CNT_W         = 6;

`ifdef MULT_UNSIGNED_EN
    // Operands are extended to 33 bits so unsigned values fit as positive
    // two's-complement numbers.
    localparam int ITER = ITER_UNSIGNED;
    localparam int QW   = WIDTH + 1;
`else
    localparam int ITER = ITER_SIGNED;
    localparam int QW   = WIDTH;
`endif

    // One guard bit above the multiplier width keeps -M representable when
    // the multiplicand is the most negative value.
    localparam int AW = QW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of the pair {Q[0], Q-1}.
    function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
        booth_op_e op;
        case ({q0, q_m1})
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: conditional add/subtract of M into the
// accumulator followed by an arithmetic shift right of {Acc, Q, Q-1}.
module booth_step
    import mult_pkg::*;
(
    input  logic [AW-1:0] acc_i,
    input  logic [QW-1:0] q_i,
    input  logic          q_m1_i,
    input  logic [AW-1:0] m_i,
    output logic [AW-1:0] acc_o,
    output logic [QW-1:0] q_o,
    output logic          q_m1_o
);

    booth_op_e     op;
    logic [AW-1:0] sum;

    // Recode, add/subtract, then shift the whole {Acc, Q, Q-1} chain by one.
    always_comb begin
        op = booth_decode(q_i[0], q_m1_i);
        case (op)
            ADD:     sum = acc_i + m_i;
            SUB:     sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
        acc_o  = {sum[AW-1], sum[AW-1:1]};
        q_o    = {sum[0], q_i[QW-1:1]};
        q_m1_o = q_i[0];
    end

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier, 32x32 -> 64 bits.
// IDLE accepts Start, RUN performs ITER Booth steps (Busy=1), DONE pulses
// Done for one cycle as Hi/Lo take the new product.
// Optional feature macro: MULT_UNSIGNED_EN adds the Uns input (1 = treat A
// and B as unsigned) and one extra iteration.
// Handshake: Start is a level sampled only in IDLE; the request is taken on
// that edge and further Start pulses are ignored until the FSM is back in
// IDLE. Done is a single-cycle pulse; Hi/Lo stay stable until the next one.
module booth_mult
    import mult_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MULT_UNSIGNED_EN
    input  logic             Uns,
`endif
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output state_e           dbg_state
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    acc_q,   acc_d;
    logic [AW-1:0]    m_q,     m_d;
    logic [QW-1:0]    q_q,     q_d;
    logic             q_m1_q,  q_m1_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [QW-1:0]    a_ext;
    logic [QW-1:0]    b_ext;
    logic [AW-1:0]    step_acc;
    logic [QW-1:0]    step_q;
    logic             step_q_m1;
    logic [AW+QW-1:0] prod;
    logic             prod_sign_unused;

    booth_step u_step (
        .acc_i  (acc_q),
        .q_i    (q_q),
        .q_m1_i (q_m1_q),
        .m_i    (m_q),
        .acc_o  (step_acc),
        .q_o    (step_q),
        .q_m1_o (step_q_m1)
    );

    // Operand extension to the internal multiplier width.
    always_comb begin
`ifdef MULT_UNSIGNED_EN
        a_ext = {(Uns ? 1'b0 : A[WIDTH-1]), A};
        b_ext = {(Uns ? 1'b0 : B[WIDTH-1]), B};
`else
        a_ext = A;
        b_ext = B;
`endif
    end

    // Full product after the current step; only the low 64 bits are
    // reported, the bits above are sign copies and carry no information.
    always_comb begin
        prod             = {step_acc, step_q};
        prod_sign_unused = ^prod[AW+QW-1:2*WIDTH];
    end

    // Next-state and datapath control for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        q_m1_d  = q_m1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    m_d     = {a_ext[QW-1], a_ext};
                    q_d     = b_ext;
                    acc_d   = '0;
                    q_m1_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                acc_d  = step_acc;
                q_d    = step_q;
                q_m1_d = step_q_m1;
                cnt_d  = cnt_q + 1'b1;
                busy_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Final step: publish the finished product in one go so
                    // Hi/Lo never expose partial results.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous active-low reset wins over Start.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q_m1_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q_m1_q  <= q_m1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign dbg_state = state_q;

endmodule
